// File: rtl/serial_shift_unit_pkg.sv
// Shared types and defaults for the serial shift/rotate unit.
// Imported by the interface, the step logic and the top.
package shift_pkg;

  localparam int WIDTH_D = 8;
  localparam int CNT_W_D = 3;

  typedef enum logic [1:0] {
    SHL = 2'd0,
    SHR = 2'd1,
    ROL = 2'd2,
    ROR = 2'd3
  } shift_fn_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_shift_unit_if.sv
// Request/result handshake bundle of the serial shift unit.
// master = controller/consumer side, slave = the unit.
interface serial_shift_unit_if
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int CNT_W = CNT_W_D
) ();

  logic             in_valid;
  logic             in_ready;
  shift_fn_e        fn;
  logic [CNT_W-1:0] shift_count;
  logic [WIDTH-1:0] data_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;
  logic             carry_out;
  logic             zero_out;

  modport master (
    output in_valid, fn, shift_count, data_in, out_ready,
    input  in_ready, out_valid, data_out, carry_out, zero_out
  );

  modport slave (
    input  in_valid, fn, shift_count, data_in, out_ready,
    output in_ready, out_valid, data_out, carry_out, zero_out
  );

endinterface

// File: rtl/serial_shift_unit_step.sv
// One-position shift/rotate step, combinational.
// Rotates pass the carry through untouched (it is cleared at accept).
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_D
) (
  input  shift_fn_e        fn,
  input  logic [WIDTH-1:0] value,
  input  logic             carry_in,
  output logic [WIDTH-1:0] value_next,
  output logic             carry_next
);

  always_comb begin
    value_next = value;
    carry_next = carry_in;
    unique case (fn)
      SHL: begin
        value_next = {value[WIDTH-2:0], 1'b0};
        carry_next = value[WIDTH-1];
      end
      SHR: begin
        value_next = {1'b0, value[WIDTH-1:1]};
        carry_next = value[0];
      end
      ROL: value_next = {value[WIDTH-2:0], value[WIDTH-1]};
      ROR: value_next = {value[0], value[WIDTH-1:1]};
    endcase
  end

endmodule

// File: rtl/serial_shift_unit.sv
// Multi-cycle shift/rotate engine: one bit position per clock,
// valid/ready on both request and result sides.
module serial_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int CNT_W = CNT_W_D
) (
  input logic          clk,
  input logic          rst_n,
  serial_shift_unit_if.slave bus
);

  state_e           state;
  shift_fn_e        fn_q;
  logic [WIDTH-1:0] work;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] work_nxt;
  logic             carry_nxt;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .fn         (fn_q),
    .value      (work),
    .carry_in   (carry),
    .value_next (work_nxt),
    .carry_next (carry_nxt)
  );

  assign bus.in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      fn_q          <= SHL;
      work          <= '0;
      carry         <= 1'b0;
      cnt           <= '0;
      bus.out_valid <= 1'b0;
      bus.data_out  <= '0;
      bus.carry_out <= 1'b0;
      bus.zero_out  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            work  <= bus.data_in;
            fn_q  <= bus.fn;
            cnt   <= bus.shift_count;
            carry <= 1'b0;
            // zero count publishes the operand directly
            if (bus.shift_count == '0) begin
              state         <= DONE;
              bus.out_valid <= 1'b1;
              bus.data_out  <= bus.data_in;
              bus.carry_out <= 1'b0;
              bus.zero_out  <= (bus.data_in == '0);
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work  <= work_nxt;
          carry <= carry_nxt;
          cnt   <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.data_out  <= work_nxt;
            bus.carry_out <= carry_nxt;
            bus.zero_out  <= (work_nxt == '0);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_shift_unit.sv
// Directed-vector bench for serial_shift_unit.
// Table vectors plus hold, back-pressure and mid-shift reset sequences.
module tb_serial_shift_unit;
  import shift_pkg::*;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  serial_shift_unit_if #(.WIDTH(8), .CNT_W(3)) bus ();

  serial_shift_unit #(.WIDTH(8), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    shift_fn_e  fn;
    logic [2:0] cnt;
    logic [7:0] din;
    logic [7:0] dout;
    logic       c;
    logic       z;
    int         lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Present a request in IDLE, return cycles until out_valid (bounded)
  task automatic issue(input shift_fn_e f, input logic [2:0] c,
                       input logic [7:0] d, output int lat);
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.fn          = f;
    bus.shift_count = c;
    bus.data_in     = d;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic drain();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("drain_out_valid", int'(bus.out_valid), 0);
    check("drain_in_ready", int'(bus.in_ready), 1);
  endtask

  initial begin
    int lat;
    int seen;
    n_vec = 0;
    n_bad = 0;

    vecs[0]  = '{SHL, 3'd3, 8'hB4, 8'hA0, 1'b1, 1'b0, 4};
    vecs[1]  = '{SHR, 3'd1, 8'h81, 8'h40, 1'b1, 1'b0, 2};
    vecs[2]  = '{SHR, 3'd7, 8'h80, 8'h01, 1'b0, 1'b0, 8};
    vecs[3]  = '{ROL, 3'd4, 8'h96, 8'h69, 1'b0, 1'b0, 5};
    vecs[4]  = '{ROR, 3'd1, 8'h01, 8'h80, 1'b0, 1'b0, 2};
    vecs[5]  = '{SHL, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1};
    vecs[6]  = '{SHL, 3'd1, 8'h80, 8'h00, 1'b1, 1'b1, 2};
    vecs[7]  = '{SHR, 3'd0, 8'h3C, 8'h3C, 1'b0, 1'b0, 1};
    vecs[8]  = '{ROR, 3'd7, 8'h0F, 8'h1E, 1'b0, 1'b0, 8};
    vecs[9]  = '{SHL, 3'd7, 8'hFF, 8'h80, 1'b1, 1'b0, 8};
    vecs[10] = '{SHR, 3'd1, 8'h01, 8'h00, 1'b1, 1'b1, 2};
    vecs[11] = '{ROL, 3'd0, 8'h81, 8'h81, 1'b0, 1'b0, 1};
    vecs[12] = '{ROL, 3'd7, 8'hA5, 8'hD2, 1'b0, 1'b0, 8};
    vecs[13] = '{SHL, 3'd2, 8'h55, 8'h54, 1'b1, 1'b0, 3};

    bus.in_valid    = 1'b0;
    bus.fn          = SHL;
    bus.shift_count = '0;
    bus.data_in     = '0;
    bus.out_ready   = 1'b0;
    rst_n           = 1'b0;
    #1;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_data_out", int'(bus.data_out), 0);
    check("rst_carry_out", int'(bus.carry_out), 0);
    check("rst_zero_out", int'(bus.zero_out), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i].fn, vecs[i].cnt, vecs[i].din, lat);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_data", i), int'(bus.data_out), int'(vecs[i].dout));
      check($sformatf("v%0d_carry", i), int'(bus.carry_out), int'(vecs[i].c));
      check($sformatf("v%0d_zero", i), int'(bus.zero_out), int'(vecs[i].z));
      drain();
    end

    // Back-pressure in DONE with a competing request on the input
    issue(SHL, 3'd3, 8'hB4, lat);
    check("hold_latency", lat, 4);
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.fn          = SHR;
    bus.shift_count = 3'd2;
    bus.data_in     = 8'h3C;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("hold%0d_valid", k), int'(bus.out_valid), 1);
      check($sformatf("hold%0d_data", k), int'(bus.data_out), 8'hA0);
      check($sformatf("hold%0d_carry", k), int'(bus.carry_out), 1);
      check($sformatf("hold%0d_in_ready", k), int'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("hs_out_valid", int'(bus.out_valid), 0);
    check("hs_in_ready", int'(bus.in_ready), 1);
    check("hs_data_kept", int'(bus.data_out), 8'hA0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("next_taken", int'(bus.in_ready), 0);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("next_latency", lat, 3);
    check("next_data", int'(bus.data_out), 8'h0F);
    check("next_carry", int'(bus.carry_out), 0);
    drain();

    // Reset during the second SHIFT cycle of a count-6 rotate
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.fn          = ROR;
    bus.shift_count = 3'd6;
    bus.data_in     = 8'h5A;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", int'(bus.out_valid), 0);
    check("abort_data_out", int'(bus.data_out), 0);
    check("abort_carry_out", int'(bus.carry_out), 0);
    check("abort_in_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("abort_no_stale", seen, 0);

    issue(ROR, 3'd2, 8'h03, lat);
    check("post_rst_latency", lat, 3);
    check("post_rst_data", int'(bus.data_out), 8'hC0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_shift_unit.md
Name: serial_shift_unit

Overview:
- Multi-cycle, one-bit-per-cycle shift/rotate engine for the 8-bit datapath.
- Uses the same fn encoding as the combinational shifter: SHL=0, SHR=1, ROL=2, ROR=3.
- Sits between the controller (request side) and the writeback/flag logic (result side), with a valid/ready handshake on each side.
- Trades latency for area: count N costs N cycles. Result and carry are bit-identical to the combinational shifter's definitions given below.

Parameters:
WIDTH, 8, operand/result width in bits
CNT_W, 3, shift-count width; legal counts are 0..2**CNT_W-1

Ports:
clk  input  1  single clock; all flops on rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  request valid
in_ready  output  1  unit can accept a request (high only in IDLE)
fn  input  2  operation: 0 SHL, 1 SHR, 2 ROL, 3 ROR
shift_count  input  CNT_W  number of bit positions
data_in  input  WIDTH  operand
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
data_out  output  WIDTH  result
carry_out  output  1  carry flag
zero_out  output  1  high when data_out == 0

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, data_out=0, carry_out=0, zero_out=0, out_valid=0, internal count=0.
- in_ready=1 whenever state is IDLE, including while in reset.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch data_in into the working register, latch fn and shift_count, clear carry.
  - Next state is SHIFT if count != 0, else DONE.
- SHIFT, one step per cycle, then count decrements:
  - SHL: carry <= reg[WIDTH-1]; reg <= reg<<1, zero fill.
  - SHR: carry <= reg[0]; reg <= reg>>1, zero fill.
  - ROL: reg <= {reg[WIDTH-2:0], reg[WIDTH-1]}; carry stays 0.
  - ROR: reg <= {reg[0], reg[WIDTH-1:1]}; carry stays 0.
  - Go to DONE on the step where count reaches 0.
- Resulting arithmetic, for count N:
  - SHL: carry = data_in[WIDTH-N].
  - SHR: carry = data_in[N-1].
  - N=0: result = data_in, carry = 0 for every fn.
- DONE:
  - out_valid=1; data_out, carry_out and zero_out are driven from registers and held stable while out_ready=0.
  - On out_ready: go to IDLE, out_valid=0 next cycle.
  - No same-cycle re-acceptance: the earliest next request is accepted the cycle after the handshake.
- Latency, from the accepting edge to out_valid high: count N gives N+1 cycles; count 0 gives 1 cycle.
- in_ready=0 in SHIFT and DONE. in_valid, fn, shift_count and data_in are ignored there; latched values must not change.
- zero_out is registered, computed from the final result on entry to DONE.
- data_out, carry_out and zero_out keep their last values after leaving DONE until the next result.
- Reset asserted mid-SHIFT or in DONE: the in-flight operation is discarded and all outputs take reset values immediately. No result is ever presented for the aborted request.
- fn is a 2-bit field; all four codes are legal and there is no illegal-op path.

Decomposition:
- Package shift_pkg:
  - shift_fn_e enum (SHL, SHR, ROL, ROR).
  - state_e enum (IDLE, SHIFT, DONE).
  - Default WIDTH/CNT_W constants.
- One natural sub-module: shift_step, combinational.
  - Inputs: fn, reg, carry_in.
  - Outputs: next reg, next carry.
  - Used once per cycle by the FSM; unit-testable against the arithmetic rules above.

Test Plan:
1. SHL, data_in=8'hB4, count 3 -> after 4 cycles: data_out=8'hA0, carry_out=1, zero_out=0, out_valid=1.
2. SHR, 8'h81, count 1 -> 8'h40, carry 1. SHR, 8'h80, count 7 -> 8'h01, carry 0, latency 8 cycles.
3. ROL, 8'h96, count 4 -> 8'h69, carry 0. ROR, 8'h01, count 1 -> 8'h80, carry 0.
4. SHL, 8'h00, count 0 -> out_valid 1 cycle after acceptance, data_out=8'h00, zero_out=1, carry_out=0. SHL, 8'h80, count 1 -> 8'h00, carry 1, zero 1.
5. Hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> outputs stable, in_ready=0, request not taken. Then out_ready=1 -> IDLE, and the new request is accepted the following cycle.
6. Assert rst_n=0 in the 2nd SHIFT cycle of a count-6 ROR -> out_valid=0, data_out=0, carry_out=0, in_ready=1 with no clock edge. After release, no stale result ever appears.
